// File: rtl/fft_arb_pkg.sv
// Shared types and defaults for the FFT-side SDRAM arbiter.
package fft_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    typedef logic req_id_t;

    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_MAX_PEND = 8;
    localparam int unsigned DEFAULT_HOLD     = 64;

endpackage

// File: rtl/fft_sdram_arbiter_if.sv
// Avalon-MM pipelined-read bus bundle; master drives commands, slave answers.
interface fft_sdram_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/fft_arb_id_fifo.sv
// Issue-order FIFO of requester ids for outstanding reads; pointers carry a wrap bit.
module fft_arb_id_fifo
    import fft_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_MAX_PEND
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  req_id_t din,
    output req_id_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
        dout = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            mem_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/fft_sdram_arbiter.sv
// Round-robin share of one SDRAM master port between two FFT requesters,
// with a bounded hold per grant and in-order routing of read returns.
module fft_sdram_arbiter
    import fft_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned MAX_PEND = DEFAULT_MAX_PEND,
    parameter int unsigned HOLD     = DEFAULT_HOLD
) (
    input  logic                clk,
    input  logic                rst,
    fft_sdram_arbiter_if.slave  req0,
    fft_sdram_arbiter_if.slave  req1,
    fft_sdram_arbiter_if.master m,
    output logic [1:0]          grant,
    output logic                err
);

    localparam int unsigned HOLD_W = $clog2(HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    req_id_t           last_q, last_d;
    logic              err_q, err_d;

    req_id_t           owner_id;
    logic              own;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic              o_rd, o_wr, own_strobe, other_req;
    logic              strobe0, strobe1;
    logic              read_block, o_wait, accepted;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    req_id_t           fifo_dout;

    fft_arb_id_fifo #(
        .DEPTH(MAX_PEND)
    ) u_id_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (owner_id),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Owner command select and acceptance, shared by next-state and output logic.
    always_comb begin
        strobe0  = req0.read | req0.write;
        strobe1  = req1.read | req1.write;
        owner_id = req_id_t'(state_q == ARB_OWN1);
        own      = (state_q != ARB_IDLE);
        if (owner_id) begin
            o_addr    = req1.address;
            o_wdata   = req1.writedata;
            o_rd      = req1.read;
            o_wr      = req1.write;
            other_req = strobe0;
        end else begin
            o_addr    = req0.address;
            o_wdata   = req0.writedata;
            o_rd      = req0.read;
            o_wr      = req0.write;
            other_req = strobe1;
        end
        own_strobe = o_rd | o_wr;
        read_block = fifo_full & o_rd;
        o_wait     = m.waitrequest | read_block;
        accepted   = own & own_strobe & ~o_wait;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            hold_q  <= '0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                hold_d = '0;
                if (strobe0 && strobe1) begin
                    state_d = last_q ? ARB_OWN0 : ARB_OWN1;
                end else if (strobe0) begin
                    state_d = ARB_OWN0;
                end else if (strobe1) begin
                    state_d = ARB_OWN1;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (accepted && hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Only let go between commands so a stalled command is never withdrawn.
                if (other_req && (!own_strobe || (accepted && hold_q == HOLD_LAST))) begin
                    state_d = owner_id ? ARB_OWN0 : ARB_OWN1;
                    last_d  = owner_id;
                    hold_d  = '0;
                end else if (!own_strobe) begin
                    state_d = ARB_IDLE;
                    last_d  = owner_id;
                    hold_d  = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        m.address   = own ? o_addr : '0;
        m.writedata = own ? o_wdata : '0;
        m.read      = own & o_rd & ~fifo_full;
        m.write     = own & o_wr;

        req0.waitrequest = (state_q == ARB_OWN0) ? o_wait : 1'b1;
        req1.waitrequest = (state_q == ARB_OWN1) ? o_wait : 1'b1;

        fifo_push = accepted & o_rd;
        fifo_pop  = m.readdatavalid & ~fifo_empty;

        req0.readdatavalid = fifo_pop & (fifo_dout == 1'b0);
        req1.readdatavalid = fifo_pop & (fifo_dout == 1'b1);
        req0.readdata      = m.readdata;
        req1.readdata      = m.readdata;

        err_d = err_q | (m.readdatavalid & fifo_empty);
        err   = err_q;
        grant = {state_q == ARB_OWN1, state_q == ARB_OWN0};
    end

endmodule

// File: tb/tb_fft_sdram_arbiter.sv
// Scoreboard bench: requester and SDRAM models around fft_sdram_arbiter.
module tb_fft_sdram_arbiter;
    import fft_arb_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int LAT = 3;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } ret_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       err;

    always #5 clk = ~clk;

    fft_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req0_if ();
    fft_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req1_if ();
    fft_sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    fft_sdram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_PEND(8),
        .HOLD    (64)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0_if),
        .req1 (req1_if),
        .m    (m_if),
        .grant(grant),
        .err  (err)
    );

    cmd_t        cmd_q0[$];
    cmd_t        cmd_q1[$];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    ret_t        ret_q[$];
    int          run_owner[$];
    int          run_len[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          sd_hold = 1'b0;
    bit          sd_spur = 1'b0;
    int          sd_wait = 0;
    int          m_rd_cnt, m_wr_cnt, rdv_cnt0, rdv_cnt1;
    logic [31:0] m_wr_addr, m_wr_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sd_data(input logic [31:0] a);
        return (a == 32'h7000) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic bit drained();
        return cmd_q0.size() == 0 && cmd_q1.size() == 0 && exp_q0.size() == 0 &&
               exp_q1.size() == 0 && ret_q.size() == 0;
    endfunction

    task automatic model_sample(input bit drove);
        cmd_t c;
        ret_t r;
        int   own;
        if ((req0_if.read || req0_if.write) && !req0_if.waitrequest) begin
            c = cmd_q0.pop_front();
            if (!c.wr) exp_q0.push_back(sd_data(c.addr));
        end
        if ((req1_if.read || req1_if.write) && !req1_if.waitrequest) begin
            c = cmd_q1.pop_front();
            if (!c.wr) exp_q1.push_back(sd_data(c.addr));
        end
        if (req0_if.readdatavalid) begin
            rdv_cnt0++;
            check_eq("rdv0_expected", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) check_eq("rdata0", req0_if.readdata, exp_q0.pop_front());
        end
        if (req1_if.readdatavalid) begin
            rdv_cnt1++;
            check_eq("rdv1_expected", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) check_eq("rdata1", req1_if.readdata, exp_q1.pop_front());
        end
        if (m_if.write && !m_if.waitrequest) begin
            m_wr_cnt++;
            m_wr_addr = m_if.address;
            m_wr_data = m_if.writedata;
        end
        if (m_if.read && !m_if.waitrequest) begin
            r.data = sd_data(m_if.address);
            r.due  = cyc + LAT;
            ret_q.push_back(r);
            m_rd_cnt++;
            own = int'(m_if.address[13]);
            if (run_owner.size() == 0 || run_owner[run_owner.size()-1] != own) begin
                run_owner.push_back(own);
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1]++;
            end
        end
        if (drove) r = ret_q.pop_front();
        if (sd_wait > 0 && (m_if.read || m_if.write)) sd_wait--;
    endtask

    // One clock: drive at the falling edge, sample just before the rising edge.
    task automatic step();
        bit drove;
        @(negedge clk);
        req0_if.address   = (cmd_q0.size() != 0) ? cmd_q0[0].addr : '0;
        req0_if.writedata = (cmd_q0.size() != 0) ? cmd_q0[0].data : '0;
        req0_if.read      = (cmd_q0.size() != 0) && !cmd_q0[0].wr;
        req0_if.write     = (cmd_q0.size() != 0) && cmd_q0[0].wr;
        req1_if.address   = (cmd_q1.size() != 0) ? cmd_q1[0].addr : '0;
        req1_if.writedata = (cmd_q1.size() != 0) ? cmd_q1[0].data : '0;
        req1_if.read      = (cmd_q1.size() != 0) && !cmd_q1[0].wr;
        req1_if.write     = (cmd_q1.size() != 0) && cmd_q1[0].wr;
        drove = 1'b0;
        m_if.waitrequest = (sd_wait > 0);
        if (sd_spur) begin
            m_if.readdatavalid = 1'b1;
            m_if.readdata      = 32'hBADC_0DE5;
        end else if (!sd_hold && ret_q.size() != 0 && ret_q[0].due <= cyc) begin
            m_if.readdatavalid = 1'b1;
            m_if.readdata      = ret_q[0].data;
            drove = 1'b1;
        end else begin
            m_if.readdatavalid = 1'b0;
            m_if.readdata      = '0;
        end
        #4;
        model_sample(drove);
        sd_spur = 1'b0;
        cyc++;
    endtask

    task automatic clear_models();
        cmd_q0.delete();
        cmd_q1.delete();
        exp_q0.delete();
        exp_q1.delete();
        run_owner.delete();
        run_len.delete();
        m_rd_cnt = 0;
        m_wr_cnt = 0;
        rdv_cnt0 = 0;
        rdv_cnt1 = 0;
        sd_hold  = 1'b0;
        sd_wait  = 0;
    endtask

    task automatic do_reset();
        clear_models();
        ret_q.delete();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_drained(input string tag, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 32'(drained()), 32'd1);
    endtask

    initial begin
        cmd_t c;
        req0_if.read = 0; req0_if.write = 0; req0_if.address = 0; req0_if.writedata = 0;
        req1_if.read = 0; req1_if.write = 0; req1_if.address = 0; req1_if.writedata = 0;
        m_if.waitrequest = 0; m_if.readdatavalid = 0; m_if.readdata = 0;
        clear_models();

        // Reset state
        do_reset();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_m_read", 32'(m_if.read), 32'd0);
        check_eq("rst_m_write", 32'(m_if.write), 32'd0);
        check_eq("rst_m_address", m_if.address, 32'd0);
        check_eq("rst_m_writedata", m_if.writedata, 32'd0);
        check_eq("rst_wait0", 32'(req0_if.waitrequest), 32'd1);
        check_eq("rst_wait1", 32'(req1_if.waitrequest), 32'd1);
        check_eq("rst_rdv0", 32'(req0_if.readdatavalid), 32'd0);
        check_eq("rst_rdv1", 32'(req1_if.readdatavalid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // Single read
        cmd_q0.push_back('{wr: 1'b0, addr: 32'h7000, data: 32'h0});
        step();
        check_eq("t1_grant_idle", 32'(grant), 32'd0);
        check_eq("t1_wait_idle", 32'(req0_if.waitrequest), 32'd1);
        step();
        check_eq("t1_grant", 32'(grant), 32'd1);
        check_eq("t1_m_address", m_if.address, 32'h7000);
        run_until_drained("t1_drain", 20);
        check_eq("t1_rdv0_cnt", 32'(rdv_cnt0), 32'd1);
        check_eq("t1_rdv1_cnt", 32'(rdv_cnt1), 32'd0);

        // Tie with streaming reads from both requesters
        do_reset();
        for (int i = 0; i < 140; i++) begin
            cmd_q0.push_back('{wr: 1'b0, addr: 32'h1000 + 32'(4 * i), data: 32'h0});
            cmd_q1.push_back('{wr: 1'b0, addr: 32'h2000 + 32'(4 * i), data: 32'h0});
        end
        run_until_drained("t2_drain", 2000);
        check_eq("t2_rd_cnt", 32'(m_rd_cnt), 32'd280);
        check_eq("t2_runs", 32'(run_owner.size() >= 3), 32'd1);
        if (run_owner.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("t2_run%0d_owner", i), 32'(run_owner[i]), 32'(i % 2));
                check_eq($sformatf("t2_run%0d_len", i), 32'(run_len[i]), 32'd64);
            end
        end
        check_eq("t2_rdv0_cnt", 32'(rdv_cnt0), 32'd140);
        check_eq("t2_rdv1_cnt", 32'(rdv_cnt1), 32'd140);

        // Write held by SDRAM wait states
        do_reset();
        sd_wait = 5;
        cmd_q1.push_back('{wr: 1'b1, addr: 32'h6001, data: 32'hCAFE_F00D});
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t3_grant", 32'(grant), 32'd2);
            check_eq("t3_m_write", 32'(m_if.write), 32'd1);
            check_eq("t3_m_address", m_if.address, 32'h6001);
            check_eq("t3_m_writedata", m_if.writedata, 32'hCAFE_F00D);
            check_eq("t3_wait1", 32'(req1_if.waitrequest), 32'd1);
        end
        step();
        for (int i = 0; i < 4; i++) step();
        check_eq("t3_wr_cnt", 32'(m_wr_cnt), 32'd1);
        check_eq("t3_wr_addr", m_wr_addr, 32'h6001);
        check_eq("t3_wr_data", m_wr_data, 32'hCAFE_F00D);
        check_eq("t3_req_done", 32'(cmd_q1.size()), 32'd0);

        // Back-pressure from a full ID FIFO
        do_reset();
        sd_hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cmd_q0.push_back('{wr: 1'b0, addr: 32'h3000 + 32'(4 * i), data: 32'h0});
        end
        for (int i = 0; i < 20; i++) step();
        check_eq("t4_rd_cnt_full", 32'(m_rd_cnt), 32'd8);
        check_eq("t4_m_read", 32'(m_if.read), 32'd0);
        check_eq("t4_wait0", 32'(req0_if.waitrequest), 32'd1);
        check_eq("t4_grant", 32'(grant), 32'd1);
        sd_hold = 1'b0;
        run_until_drained("t4_drain", 100);
        check_eq("t4_rd_cnt", 32'(m_rd_cnt), 32'd9);
        check_eq("t4_rdv0_cnt", 32'(rdv_cnt0), 32'd9);

        // Spurious return
        do_reset();
        step();
        sd_spur = 1'b1;
        step();
        check_eq("t5_rdv0", 32'(req0_if.readdatavalid), 32'd0);
        check_eq("t5_rdv1", 32'(req1_if.readdatavalid), 32'd0);
        step();
        check_eq("t5_err", 32'(err), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check_eq("t5_err_held", 32'(err), 32'd1);

        // Reset with reads outstanding
        do_reset();
        check_eq("t6_err_clear", 32'(err), 32'd0);
        sd_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_q0.push_back('{wr: 1'b0, addr: 32'h4000 + 32'(4 * i), data: 32'h0});
        end
        for (int i = 0; i < 10; i++) step();
        check_eq("t6_rd_cnt", 32'(m_rd_cnt), 32'd4);
        clear_models();
        sd_hold = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_grant", 32'(grant), 32'd0);
        check_eq("t6_err_rst", 32'(err), 32'd0);
        sd_hold = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_eq("t6_rdv0_cnt", 32'(rdv_cnt0), 32'd0);
        check_eq("t6_rdv1_cnt", 32'(rdv_cnt1), 32'd0);
        check_eq("t6_err", 32'(err), 32'd1);
        check_eq("t6_sdram_drained", 32'(ret_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
